// File: rtl/pll_reconfig_responder.sv
// Avalon-MM stand-in for the PLL reconfiguration IP: MODE/STATUS/START/FRAC_K registers,
// modelled reconfig busy time and relock. Define PLL_RECONFIG_READBACK_EN to make reads return register contents.
module pll_reconfig_responder #(
  parameter logic [31:0] DEFAULT_K     = 32'd3639383488,
  parameter int unsigned RECONF_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES   = 32
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic        pll_locked,
  output logic [31:0] active_k,
  output logic [7:0]  reconfig_count
);

`ifdef PLL_RECONFIG_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  localparam logic [5:0]  A_MODE    = 6'd0;
  localparam logic [5:0]  A_STATUS  = 6'd1;
  localparam logic [5:0]  A_START   = 6'd2;
  localparam logic [5:0]  A_FRAC_K  = 6'd7;
  localparam logic [15:0] RECONF_LD = 16'(RECONF_CYCLES);
  localparam logic [15:0] LOCK_LD   = 16'(LOCK_CYCLES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RECONFIG, RELOCK} state_t;

  state_t      state_q, state_d, ret_q, ret_d, phase, nph;
  logic [15:0] cnt_q, cnt_d;
  logic        mode_q, mode_d, err_q, err_d, locked_q, locked_d;
  logic [31:0] shadow_q, shadow_d, active_q, active_d, rdata_q, rdata_d, rd_mux;
  logic [7:0]  count_q, count_d;
  logic        busy, wr_stall, wr_acc, rd_start;

  always_comb begin
    // RD_WAIT overlays the underlying phase so the busy timers keep running during a read
    phase    = (state_q == RD_WAIT) ? ret_q : state_q;
    busy     = (phase == RECONFIG) || (phase == RELOCK);
    wr_stall = busy && !mode_q;
    wr_acc   = mgmt_write && !wr_stall;
    rd_start = mgmt_read && !mgmt_write && (state_q != RD_WAIT) && !wr_stall;
    if (mgmt_write) begin
      mgmt_waitrequest = wr_stall;
    end else begin
      mgmt_waitrequest = mgmt_read && (state_q != RD_WAIT);
    end

    case (mgmt_address)
      A_MODE:   rd_mux = {31'd0, mode_q};
      A_STATUS: rd_mux = {29'd0, err_q, locked_q, busy};
      A_FRAC_K: rd_mux = shadow_q;
      default:  rd_mux = '0;
    endcase

    nph      = phase;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    err_d    = err_q;
    locked_d = locked_q;
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    case (phase)
      RECONFIG: begin
        if (cnt_q == 16'd1) begin
          active_d = shadow_q;
          count_d  = count_q + 8'd1;
          cnt_d    = LOCK_LD;
          nph      = RELOCK;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RELOCK: begin
        if (cnt_q == 16'd1) begin
          locked_d = 1'b1;
          nph      = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: ;
    endcase

    if (wr_acc) begin
      case (mgmt_address)
        A_MODE: begin
          mode_d = mgmt_writedata[0];
          err_d  = 1'b0;
        end
        A_START: begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            nph      = RECONFIG;
            cnt_d    = RECONF_LD;
            locked_d = 1'b0;
          end
        end
        A_FRAC_K: shadow_d = mgmt_writedata;
        default: ;
      endcase
    end

    if (rd_start) begin
      state_d = RD_WAIT;
      ret_d   = nph;
      rdata_d = RB_EN ? rd_mux : 32'd0;
    end else begin
      state_d = nph;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!reset) begin
      state_q  <= RELOCK;
      ret_q    <= IDLE;
      cnt_q    <= LOCK_LD;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      shadow_q <= DEFAULT_K;
      active_q <= DEFAULT_K;
      count_q  <= 8'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mgmt_readdata  = rdata_q;
  assign pll_locked     = locked_q;
  assign active_k       = active_q;
  assign reconfig_count = count_q;

endmodule

// File: tb/tb_pll_reconfig_responder.sv
// Directed bench for pll_reconfig_responder: reset/relock timing, write sequences, both
// bus modes, reset abort and counter wrap, with hand-computed expectations.
module tb_pll_reconfig_responder;

`ifdef PLL_RECONFIG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  localparam logic [31:0] DEF_K = 32'd3639383488;
  localparam logic [5:0]  A_MODE = 6'd0, A_STATUS = 6'd1, A_START = 6'd2, A_FRAC_K = 6'd7;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic [31:0] active_k;
  logic [7:0]  reconfig_count;

  int nvec = 0;
  int nmis = 0;

  pll_reconfig_responder dut (
    .clk_50m          (clk_50m),
    .reset            (reset),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_read        (mgmt_read),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .active_k         (active_k),
    .reconfig_count   (reconfig_count)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50m);
    #2;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, output int waits);
    mgmt_address   = a;
    mgmt_writedata = d;
    mgmt_write     = 1'b1;
    waits          = 0;
    #1;
    while (mgmt_waitrequest && waits < 1000) begin
      @(posedge clk_50m);
      #3;
      waits++;
    end
    @(posedge clk_50m);
    #2;
    mgmt_write = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] data, output int waits);
    mgmt_address = a;
    mgmt_read    = 1'b1;
    waits        = 0;
    #1;
    while (mgmt_waitrequest && waits < 1000) begin
      @(posedge clk_50m);
      #3;
      waits++;
    end
    data = mgmt_readdata;
    @(posedge clk_50m);
    #2;
    mgmt_read = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!pll_locked && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_active(input logic [31:0] v, output int n);
    n = 0;
    while (active_k !== v && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, n, bad;
    logic [31:0] d;
    logic [7:0]  c255;

    reset = 1'b0; mgmt_address = '0; mgmt_write = 1'b0; mgmt_writedata = '0; mgmt_read = 1'b0;
    tick(3);
    chk("rst_locked", {31'd0, pll_locked}, 32'd0);
    chk("rst_active_k", active_k, DEF_K);
    chk("rst_count", {24'd0, reconfig_count}, 32'd0);
    chk("rst_readdata", mgmt_readdata, 32'd0);
    chk("rst_waitreq", {31'd0, mgmt_waitrequest}, 32'd0);
    reset = 1'b1;
    wait_lock(n);
    chk("rst_lock_latency", n, 32);

    // basic MODE / FRAC_K / START sequence
    do_write(A_MODE, 32'd0, w);          chk("seq_wr_mode_wait", w, 0);
    do_write(A_FRAC_K, 32'd2977614927, w); chk("seq_wr_frac_wait", w, 0);
    do_write(A_START, 32'd1, w);         chk("seq_wr_start_wait", w, 0);
    chk("seq_lock_drop", {31'd0, pll_locked}, 32'd0);
    chk("seq_active_hold", active_k, DEF_K);
    wait_active(32'd2977614927, n);
    chk("seq_apply_latency", n, 16);
    wait_lock(n);
    chk("seq_relock_latency", n, 32);
    chk("seq_count", {24'd0, reconfig_count}, 32'd1);

    // waitrequest mode: write stalled through the busy window
    do_write(A_START, 32'd0, w);
    tick(3);
    do_write(A_FRAC_K, 32'h1234_5678, w);
    chk("wrq_stall_cycles", w, 45);
    chk("wrq_active_unchanged", active_k, 32'd2977614927);
    chk("wrq_count", {24'd0, reconfig_count}, 32'd2);
    do_read(A_FRAC_K, d, w);
    chk("wrq_rd_latency", w, 1);
    chk("wrq_rd_shadow", d, RB ? 32'h1234_5678 : 32'd0);
    do_write(A_START, 32'd0, w);
    wait_active(32'h1234_5678, n);
    chk("wrq_apply_latency", n, 16);
    wait_lock(n);
    chk("wrq_count2", {24'd0, reconfig_count}, 32'd3);

    // polling mode: START while busy is flagged, not counted
    do_write(A_MODE, 32'd1, w);
    do_write(A_FRAC_K, 32'h0F0F_0F0F, w);
    do_write(A_START, 32'd0, w);
    tick(2);
    do_write(A_START, 32'd0, w);
    chk("poll_start_busy_wait", w, 0);
    do_read(A_STATUS, d, w);
    chk("poll_status_latency", w, 1);
    chk("poll_status_busy_err", d, RB ? 32'd5 : 32'd0);
    wait_active(32'h0F0F_0F0F, n);
    do_write(A_FRAC_K, 32'hAAAA_0001, w);
    chk("poll_frac_busy_wait", w, 0);
    chk("poll_active_after_frac", active_k, 32'h0F0F_0F0F);
    wait_lock(n);
    chk("poll_count", {24'd0, reconfig_count}, 32'd4);
    chk("poll_active_final", active_k, 32'h0F0F_0F0F);
    do_read(A_STATUS, d, w);
    chk("poll_status_sticky", d, RB ? 32'd6 : 32'd0);
    do_write(A_MODE, 32'd1, w);
    do_read(A_STATUS, d, w);
    chk("poll_status_cleared", d, RB ? 32'd2 : 32'd0);
    do_read(A_FRAC_K, d, w);
    chk("poll_shadow_rd", d, RB ? 32'hAAAA_0001 : 32'd0);
    do_read(6'd5, d, w);
    chk("unmapped_rd", d, 32'd0);

    // reset in the middle of RECONFIG
    do_write(A_FRAC_K, 32'd123, w);
    do_write(A_START, 32'd0, w);
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("abort_active_k", active_k, DEF_K);
    chk("abort_count", {24'd0, reconfig_count}, 32'd0);
    chk("abort_locked", {31'd0, pll_locked}, 32'd0);
    reset = 1'b1;
    wait_lock(n);
    chk("abort_relock_latency", n, 32);
    chk("abort_active_after", active_k, DEF_K);
    do_read(A_MODE, d, w);
    chk("abort_mode_rd", d, 32'd0);

    // 256 reconfigurations in polling mode
    do_write(A_MODE, 32'd1, w);
    bad  = 0;
    c255 = '0;
    for (int i = 0; i < 256; i++) begin
      do_write(A_START, 32'd0, w);
      if (w != 0) bad++;
      do_read(A_STATUS, d, w);
      if (w != 1 || d !== (RB ? 32'd1 : 32'd0)) bad++;
      wait_lock(n);
      if (n >= 200) bad++;
      do_read(A_STATUS, d, w);
      if (w != 1 || d !== (RB ? 32'd2 : 32'd0)) bad++;
      if (i == 254) c255 = reconfig_count;
    end
    chk("wrap_count_255", {24'd0, c255}, 32'd255);
    chk("wrap_count_0", {24'd0, reconfig_count}, 32'd0);
    chk("wrap_status_errors", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_responder.md
Name: pll_reconfig_responder

Overview:
- Cycle-level responder for the PLL reconfiguration management bus: the Avalon-MM slave end of the mode/frac-K/start write sequence that the top-level PLL-underclock sequencer issues.
- Holds shadow and active register sets and models the reconfiguration busy time and the loss and regain of lock.
- Exports the applied fractional-K value and the lock status.
- Used in simulation and as a drop-in stand-in for the vendor reconfig IP, so the sequencer can be verified without it.

Parameters:
- DEFAULT_K, 32'd3639383488, fractional-K loaded into shadow and active registers at reset (native clock).
- RECONF_CYCLES, 16, clk_50m cycles spent in RECONFIG after a start write; legal range 1–65535.
- LOCK_CYCLES, 32, clk_50m cycles from the end of RECONFIG until pll_locked rises; legal range 1–65535.

Ports:
- clk_50m  in  1  management clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- mgmt_address  in  6  register word address.
- mgmt_write  in  1  write request.
- mgmt_writedata  in  32  write data.
- mgmt_read  in  1  read request.
- mgmt_readdata  out  32  read data; valid in the cycle a read completes.
- mgmt_waitrequest  out  1  high = current request not accepted; the master holds the request.
- pll_locked  out  1  modelled PLL lock.
- active_k  out  32  fractional-K currently applied.
- reconfig_count  out  8  number of completed reconfigurations; wraps 255→0.

Behaviour:
- Register map:
  - 0 MODE: bit0 = 0 waitrequest mode, 1 polling mode.
  - 1 STATUS (read-only): bit0 busy, bit1 locked, bit2 start_err (sticky, cleared by writing MODE).
  - 2 START: any write triggers a reconfiguration.
  - 7 FRAC_K shadow.
  - All other addresses: writes ignored, reads return 0.
- Reset (reset=0 at a clock edge):
  - MODE=0, shadow_k=active_k=DEFAULT_K, reconfig_count=0, start_err=0, mgmt_readdata=0.
  - mgmt_waitrequest=0, pll_locked=0.
  - State=RELOCK with the counter loaded to LOCK_CYCLES.
  - pll_locked rises LOCK_CYCLES cycles after the first edge with reset=1.
  - Reset mid-RECONFIG aborts the reconfiguration; shadow_k is not applied.
- States: IDLE, RD_WAIT, RECONFIG, RELOCK.
- IDLE:
  - Write while mgmt_waitrequest=0 is accepted in that cycle; the register updates on that edge.
  - Write to START goes to RECONFIG next cycle; the counter is loaded to RECONF_CYCLES and pll_locked drops on the same edge.
- Reads:
  - The first cycle of mgmt_read has mgmt_waitrequest=1 and the block enters RD_WAIT.
  - In the next cycle mgmt_waitrequest=0, mgmt_readdata is valid, and the block returns to the previous state; read latency is exactly 1 wait cycle.
  - If mgmt_read and mgmt_write are both high, the write has priority and the read is stalled.
- RECONFIG:
  - The counter decrements each cycle; at 0, active_k←shadow_k and reconfig_count increments (mod 256).
  - Then RELOCK with the counter loaded to LOCK_CYCLES.
- RELOCK: at counter 0, pll_locked←1 and the block returns to IDLE.
- Waitrequest mode:
  - mgmt_waitrequest is held 1 for any write request during RECONFIG/RELOCK; the write completes in the first IDLE cycle.
  - Reads are also stalled.
- Polling mode:
  - Writes to MODE and FRAC_K are accepted during RECONFIG/RELOCK; they update shadow only, not active_k.
  - START during busy is accepted, ignored, and sets start_err.
  - Reads proceed normally.
  - busy = (state is RECONFIG or RELOCK).
- FRAC_K written in the same cycle as a START write cannot occur (single port). The last FRAC_K value before START is the one applied.

Optional Feature:
- Macro PLL_RECONFIG_READBACK_EN.
- Defined: reads return the register contents as mapped above.
- Undefined:
  - mgmt_readdata is constant 0.
  - Reads still take exactly 1 wait cycle.
  - The STATUS logic is still present internally but not observable on the bus.

Test Plan:
- Reset release with defaults → pll_locked rises exactly 32 cycles later; active_k=3639383488; reconfig_count=0.
- Writes MODE=0, FRAC_K=2977614927, START at one per cycle →
  - waitrequest=0 on all three writes;
  - pll_locked falls the cycle after START;
  - active_k=2977614927 after 16 cycles;
  - pll_locked=1 32 cycles after that;
  - reconfig_count=1.
- Waitrequest mode, FRAC_K write issued 3 cycles after START →
  - mgmt_waitrequest held high through RECONFIG+RELOCK (45 cycles);
  - write accepted in the first IDLE cycle;
  - active_k unchanged until the next START.
- Polling mode, START during RECONFIG →
  - accepted with no stall;
  - STATUS read shows busy=1, start_err=1;
  - only one reconfig counted;
  - MODE write clears start_err.
- reset=0 asserted mid-RECONFIG after FRAC_K=123 →
  - active_k=DEFAULT_K, reconfig_count=0, pll_locked=0;
  - relock 32 cycles after release.
- 256 back-to-back reconfigurations → reconfig_count wraps to 0; STATUS read latency is always exactly 1 wait cycle.
